// File: rtl/c_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and width helper.
package c_divider_pkg;

  // log2 of the default datapath width
  localparam int N_DEFAULT = 4;

  // Controller states of the divider
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Datapath width derived from its log2
  function automatic int width_of(input int n);
    return 2 ** n;
  endfunction

endpackage

// File: rtl/c_div_step.sv
// One restoring division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference only if it did not borrow.
module c_div_step #(
  parameter int W = 16
) (
  input  logic [W:0]   p,
  input  logic         msb,
  input  logic [W-1:0] b,
  output logic [W:0]   p_next,
  output logic         q_bit
);

  logic [W:0]   p_shift;
  logic [W:0]   b_wide;
  logic [W+1:0] sum;
  logic         unused_p_top;

  // The restored partial remainder is always below the divisor, so its top bit is
  // known zero and drops out when the next dividend bit is shifted in.
  assign unused_p_top = p[W];

  // Subtract-mode adder widened to W+1 bits: p_shift + ~b + 1. The carry out of
  // the top bit is set exactly when no borrow occurred, i.e. p_shift >= b.
  always_comb begin
    p_shift = {p[W-1:0], msb};
    b_wide  = {1'b0, b};
    sum     = {1'b0, p_shift} + {1'b0, ~b_wide} + (W+2)'(1);
    q_bit   = sum[W+1];
    p_next  = q_bit ? sum[W:0] : p_shift;
  end

endmodule

// File: rtl/c_divider.sv
// Sequential restoring divider: unsigned a / b and a % b, one quotient bit per clock,
// with a start/busy/done handshake. Divide-by-zero finishes immediately with an
// all-ones quotient, the dividend as remainder and div_zero set.
module c_divider
  import c_divider_pkg::*;
#(
  parameter  int N = N_DEFAULT,
  localparam int W = width_of(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_zero
);

  state_t       state;
  state_t       state_next;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] q_acc;
  logic [W:0]   p;
  logic [W:0]   p_next;
  logic         q_bit;
  logic [N-1:0] count;
  logic         accept;
  logic         last_iter;

  c_div_step #(.W(W)) u_step (
    .p      (p),
    .msb    (dividend[W-1]),
    .b      (divisor),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  // A new request is taken whenever no iteration is in flight, including the done cycle
  assign accept    = start && (state != RUN);
  assign last_iter = (count == N'(W - 1));
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: zero divisor skips the iterations entirely
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (b == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_next = (b == '0) ? DONE : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration registers and result registers; results change only
  // on the edge that enters DONE so they stay stable between completions.
  always_ff @(posedge clk) begin
    if (rst) begin
      dividend  <= '0;
      divisor   <= '0;
      q_acc     <= '0;
      p         <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      dividend <= a;
      divisor  <= b;
      q_acc    <= '0;
      p        <= '0;
      count    <= '0;
      if (b == '0) begin
        quotient  <= '1;
        remainder <= a;
        div_zero  <= 1'b1;
      end
    end else if (state == RUN) begin
      p        <= p_next;
      q_acc    <= {q_acc[W-2:0], q_bit};
      dividend <= {dividend[W-2:0], 1'b0};
      count    <= count + N'(1);
      if (last_iter) begin
        quotient  <= {q_acc[W-2:0], q_bit};
        remainder <= p_next[W-1:0];
        div_zero  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_c_divider.sv
// Self-checking bench for c_divider: an arithmetic reference model checked every cycle,
// plus directed scenarios with literal expected results and a random invariant sweep.
module tb_c_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit           model_valid = 1'b0;
  logic         m_busy;
  logic         m_done;
  logic         m_dz;
  logic [W-1:0] m_q;
  logic [W-1:0] m_r;
  logic [W-1:0] pend_q;
  logic [W-1:0] pend_r;
  int           m_remaining;

  c_divider #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a request taken while idle finishes W edges later with a/b and a%b,
  // or on the same edge for a zero divisor; requests during a run are dropped.
  always @(posedge clk) begin
    if (rst) begin
      m_busy      = 1'b0;
      m_done      = 1'b0;
      m_dz        = 1'b0;
      m_q         = '0;
      m_r         = '0;
      m_remaining = 0;
      model_valid = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_remaining--;
        if (m_remaining == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_q    = pend_q;
          m_r    = pend_r;
          m_dz   = 1'b0;
        end
      end else if (start) begin
        if (b == '0) begin
          m_q    = '1;
          m_r    = a;
          m_dz   = 1'b1;
          m_done = 1'b1;
        end else begin
          pend_q      = a / b;
          pend_r      = a % b;
          m_busy      = 1'b1;
          m_remaining = W;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("busy", 32'(busy), 32'(m_busy));
      checkOutput("done", 32'(done), 32'(m_done));
      checkOutput("quotient", 32'(quotient), 32'(m_q));
      checkOutput("remainder", 32'(remainder), 32'(m_r));
      checkOutput("div_zero", 32'(div_zero), 32'(m_dz));
    end
  end

  // Wait for done with a bound; lat counts edges after the accepting edge
  task automatic waitDone(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < W + 4) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (!done) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  // Issue one request for a single cycle and wait for its result
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat, busy_cnt);
  endtask

  initial begin
    int          lat;
    int          bcnt;
    bit          seen_done;
    logic [31:0] rnd;
    logic [W-1:0] av;
    logic [W-1:0] bv;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_quotient", 32'(quotient), 32'd0);
    checkOutput("reset_div_zero", 32'(div_zero), 32'd0);
    rst = 1'b0;

    // 100 / 7
    applyStimulus(16'd100, 16'd7, lat, bcnt);
    checkOutput("t1_latency", 32'(lat), 32'd16);
    checkOutput("t1_busy_cycles", 32'(bcnt), 32'd16);
    checkOutput("t1_quotient", 32'(quotient), 32'd14);
    checkOutput("t1_remainder", 32'(remainder), 32'd2);
    checkOutput("t1_div_zero", 32'(div_zero), 32'd0);

    // Boundary operands
    applyStimulus(16'hFFFF, 16'd1, lat, bcnt);
    checkOutput("t2a_quotient", 32'(quotient), 32'h0000FFFF);
    checkOutput("t2a_remainder", 32'(remainder), 32'd0);
    applyStimulus(16'hFFFF, 16'hFFFF, lat, bcnt);
    checkOutput("t2b_quotient", 32'(quotient), 32'd1);
    checkOutput("t2b_remainder", 32'(remainder), 32'd0);
    applyStimulus(16'd5, 16'd9, lat, bcnt);
    checkOutput("t2c_quotient", 32'(quotient), 32'd0);
    checkOutput("t2c_remainder", 32'(remainder), 32'd5);

    // Divide by zero completes on the accepting edge without ever going busy
    applyStimulus(16'h1234, 16'd0, lat, bcnt);
    checkOutput("t3_latency", 32'(lat), 32'd0);
    checkOutput("t3_busy_cycles", 32'(bcnt), 32'd0);
    checkOutput("t3_quotient", 32'(quotient), 32'h0000FFFF);
    checkOutput("t3_remainder", 32'(remainder), 32'h00001234);
    checkOutput("t3_div_zero", 32'(div_zero), 32'd1);
    @(negedge clk);
    checkOutput("t3_done_one_cycle", 32'(done), 32'd0);
    checkOutput("t3_held_div_zero", 32'(div_zero), 32'd1);

    // Start during a run is ignored; start in the done cycle is taken back-to-back
    @(negedge clk);
    start = 1'b1;
    a     = 16'd100;
    b     = 16'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    a     = 16'd9;
    b     = 16'd3;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat, bcnt);
    checkOutput("t4_quotient", 32'(quotient), 32'd14);
    checkOutput("t4_remainder", 32'(remainder), 32'd2);
    start = 1'b1;
    a     = 16'd9;
    b     = 16'd3;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t4_b2b_busy", 32'(busy), 32'd1);
    waitDone(lat, bcnt);
    checkOutput("t4_b2b_latency", 32'(lat), 32'd16);
    checkOutput("t4_b2b_quotient", 32'(quotient), 32'd3);
    checkOutput("t4_b2b_remainder", 32'(remainder), 32'd0);

    // Reset in the middle of a run
    @(negedge clk);
    start = 1'b1;
    a     = 16'd1000;
    b     = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_done", 32'(done), 32'd0);
    checkOutput("t5_quotient", 32'(quotient), 32'd0);
    checkOutput("t5_remainder", 32'(remainder), 32'd0);
    seen_done = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    checkOutput("t5_no_done", 32'(seen_done), 32'd0);

    // Random sweep with nonzero divisors of varied magnitude
    for (int i = 0; i < 1000; i++) begin
      rnd = $urandom;
      av  = rnd[15:0];
      rnd = $urandom;
      bv  = rnd[15:0] >> rnd[19:16];
      if (bv == '0) bv = 16'd1;
      applyStimulus(av, bv, lat, bcnt);
      checkOutput("t6_identity", 32'(quotient) * 32'(bv) + 32'(remainder), 32'(av));
      checkOutput("t6_rem_below_b", 32'(remainder < bv), 32'd1);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
